uart_rx: RTL and testbench

Oversampling UART receiver that sits directly downstream of the baud/oversample tick generator. It consumes `oversample_tick` (BAUD_RATE × OVERSAMPLE), synchronises the asynchronous `rx` pin and detects start bits. Each bit is recovered by a 3-sample majority vote at mid-bit. Each received byte is presented with a single-cycle valid strobe plus error flags for the downstream command/clock-setting logic.

---
 rtl/uart_rx.sv | 98 +++++++++
 tb/tb_uart_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 3-sample mid-bit majority vote and registered strobes.
// Define UART_RX_PARITY_EN to expect one parity bit (checked per PARITY_ODD) before the stop bit.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 oversample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 busy
);
  localparam int M  = OVERSAMPLE / 2;
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t               r_state, w_state_nxt;
  logic                 r_rx_meta, r_rx_s, r_armed, r_s0, r_s1, r_par_flag;
  logic                 r_valid, r_ferr, r_perr;
  logic [CW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift, r_data;
  logic                 w_maj, w_mid, w_end, w_last_bit, w_start;
  always_comb begin
    w_maj       = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
    w_mid       = oversample_tick && (r_tick_cnt == CW'(M + 1));
    w_end       = oversample_tick && (r_tick_cnt == CW'(OVERSAMPLE - 1));
    w_last_bit  = r_bit_idx == BW'(DATA_BITS - 1);
    w_start     = oversample_tick && r_armed && !r_rx_s && r_state == S_IDLE;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = w_start ? S_START : S_IDLE;
      S_START:  w_state_nxt = (w_mid && w_maj) ? S_IDLE : w_end ? S_DATA : S_START;
      S_DATA:   w_state_nxt = (w_end && w_last_bit) ? (PAR_EN ? S_PARITY : S_STOP) : S_DATA;
      S_PARITY: w_state_nxt = w_end ? S_STOP : S_PARITY;
      S_STOP:   w_state_nxt = w_mid ? S_IDLE : S_STOP;
      default:  w_state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    r_state <= reset ? S_IDLE : w_state_nxt;
  // The start-detect tick itself is tick 0 of the start bit, so counting resumes at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
      r_armed    <= 1'b1;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_par_flag <= 1'b0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_perr     <= 1'b0;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_perr    <= 1'b0;
      if (oversample_tick) begin
        r_tick_cnt <= w_start ? CW'(1) : (w_state_nxt == S_IDLE || w_end) ? '0 : r_tick_cnt + CW'(1);
        if (r_tick_cnt == CW'(M - 1)) r_s0 <= r_rx_s;
        if (r_tick_cnt == CW'(M)) r_s1 <= r_rx_s;
        if (w_end) r_bit_idx <= (r_state == S_DATA && !w_last_bit) ? r_bit_idx + BW'(1) : '0;
        if (r_state == S_IDLE && r_rx_s) r_armed <= 1'b1;
        if (r_state == S_DATA && w_mid) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
        if (r_state == S_PARITY && w_mid) r_par_flag <= ^{r_shift, w_maj} ^ PARITY_ODD[0];
        // A low stop bit disarms the receiver so a held break cannot retrigger.
        if (r_state == S_STOP && w_mid) begin
          r_data  <= w_maj ? r_shift : r_data;
          r_valid <= w_maj;
          r_ferr  <= !w_maj;
          r_perr  <= w_maj && PAR_EN && r_par_flag;
          if (!w_maj) r_armed <= 1'b0;
        end
      end
    end
  end
  assign data_out      = r_data;
  assign data_valid    = r_valid;
  assign framing_error = r_ferr;
  assign parity_error  = r_perr;
  assign busy          = r_state != S_IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed-vector bench for uart_rx (8 data bits, 16x oversample, tick every 4 clk).
module tb_uart_rx;
  logic       clk = 1'b0, reset = 1'b1, oversample_tick = 1'b0, rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, framing_error, parity_error, busy;
  int         n_vec = 0, n_err = 0;
  int         n_valid = 0, n_ferr = 0, n_perr = 0, n_coinc = 0, n_perr_alone = 0;
  logic [7:0] data_log[$];
  time        t_valid = 0, t_start = 0;
  logic       busy_mid, snap_valid, snap_ferr, snap_perr, snap_busy;
  logic [7:0] snap_data;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .oversample_tick(oversample_tick), .rx(rx),
    .data_out(data_out), .data_valid(data_valid), .framing_error(framing_error),
    .parity_error(parity_error), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      oversample_tick = (ph == 0);
      ph = (ph + 1) % 4;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (data_valid) begin
        n_valid++;
        data_log.push_back(data_out);
        t_valid = $time;
      end
      if (framing_error) n_ferr++;
      if (parity_error) n_perr++;
      if (parity_error && !data_valid) n_perr_alone++;
      if (data_valid && framing_error) n_coinc++;
    end
  end

  // par_v < 0: no parity bit; glitch_at/rst_at are clk offsets from the start-bit edge (< 0: none).
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int par_v,
                            input int glitch_at, input int rst_at);
    logic bits [0:10];
    int   n;
    n = 0;
    bits[n] = 1'b0; n = n + 1;
    for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n = n + 1; end
    if (par_v >= 0) begin bits[n] = par_v[0]; n = n + 1; end
    bits[n] = stop_v; n = n + 1;
    for (int t = 0; t < n * 64; t++) begin
      rx = (glitch_at >= 0 && t >= glitch_at && t < glitch_at + 4) ? 1'b1 : bits[t / 64];
      reset = (t == rst_at);
      if (t == 0) t_start = $time;
      @(negedge clk);
      if (t == rst_at) begin
        snap_data = data_out; snap_valid = data_valid; snap_ferr = framing_error;
        snap_perr = parity_error; snap_busy = busy;
      end
      if (t == 5 * 64) busy_mid = busy;
    end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
    n_vec++; if (framing_error !== 1'b0) begin n_err++; $display("FAIL reset_framing_error: got %b want 0", framing_error); end
    n_vec++; if (parity_error !== 1'b0) begin n_err++; $display("FAIL reset_parity_error: got %b want 0", parity_error); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_basic();
    int v0, f0, p0;
    logic [7:0] got;
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_idle: got %b want 0", busy); end
    send_frame(8'hA5, 1'b1, -1, -1, -1);
    n_vec++; if (busy_mid !== 1'b1) begin n_err++; $display("FAIL basic_busy_mid: got %b want 1", busy_mid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    repeat (128) @(negedge clk);
    got = (data_log.size() > v0) ? data_log[v0] : 8'hxx;
    n_vec++; if (n_valid - v0 !== 1) begin n_err++; $display("FAIL basic_valid_count: got %0d want 1", n_valid - v0); end
    n_vec++; if (got !== 8'hA5) begin n_err++; $display("FAIL basic_data: got %h want a5", got); end
    n_vec++; if (n_ferr - f0 !== 0) begin n_err++; $display("FAIL basic_framing: got %0d want 0", n_ferr - f0); end
    n_vec++; if (n_perr - p0 !== 0) begin n_err++; $display("FAIL basic_parity: got %0d want 0", n_perr - p0); end
    // 2 sync clk + up to 4 clk tick phase + 153 ticks * 4 clk + 1 clk strobe register
    n_vec++;
    if ((t_valid - t_start) < 6150 || (t_valid - t_start) > 6180) begin
      n_err++; $display("FAIL basic_latency: got %0d want 6150..6180", t_valid - t_start);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    logic [7:0] g0, g1;
    v0 = n_valid;
    send_frame(8'h00, 1'b1, -1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1, -1);
    repeat (128) @(negedge clk);
    g0 = (data_log.size() > v0) ? data_log[v0] : 8'hxx;
    g1 = (data_log.size() > v0 + 1) ? data_log[v0 + 1] : 8'hxx;
    n_vec++; if (n_valid - v0 !== 2) begin n_err++; $display("FAIL b2b_valid_count: got %0d want 2", n_valid - v0); end
    n_vec++; if (g0 !== 8'h00) begin n_err++; $display("FAIL b2b_first: got %h want 00", g0); end
    n_vec++; if (g1 !== 8'hFF) begin n_err++; $display("FAIL b2b_second: got %h want ff", g1); end
  endtask

  task automatic test_glitch_start();
    int v0, f0;
    logic seen;
    v0 = n_valid; f0 = n_ferr;
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    seen = busy;
    repeat (38) @(negedge clk);
    n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL glitch_busy_rise: got %b want 1", seen); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_fall: got %b want 0", busy); end
    repeat (200) @(negedge clk);
    n_vec++; if ((n_valid - v0) + (n_ferr - f0) !== 0) begin
      n_err++; $display("FAIL glitch_no_strobe: got %0d want 0", (n_valid - v0) + (n_ferr - f0));
    end
  endtask

  task automatic test_glitch_data();
    int v0;
    v0 = n_valid;
    send_frame(8'h3C, 1'b1, -1, 64 + 32, -1);
    repeat (128) @(negedge clk);
    n_vec++; if (n_valid - v0 !== 1) begin n_err++; $display("FAIL glitch_data_count: got %0d want 1", n_valid - v0); end
    n_vec++; if (data_out !== 8'h3C) begin n_err++; $display("FAIL glitch_data_value: got %h want 3c", data_out); end
  endtask

  task automatic test_framing_break();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h55, 1'b0, -1, -1, -1);
    rx = 1'b0;
    repeat (20 * 64) @(negedge clk);
    rx = 1'b1;
    repeat (128) @(negedge clk);
    n_vec++; if (n_ferr - f0 !== 1) begin n_err++; $display("FAIL framing_count: got %0d want 1", n_ferr - f0); end
    n_vec++; if (n_valid - v0 !== 0) begin n_err++; $display("FAIL framing_no_valid: got %0d want 0", n_valid - v0); end
    n_vec++; if (data_out !== 8'h3C) begin n_err++; $display("FAIL framing_data_kept: got %h want 3c", data_out); end
    send_frame(8'h12, 1'b1, -1, -1, -1);
    repeat (128) @(negedge clk);
    n_vec++; if (n_valid - v0 !== 1) begin n_err++; $display("FAIL after_break_count: got %0d want 1", n_valid - v0); end
    n_vec++; if (data_out !== 8'h12) begin n_err++; $display("FAIL after_break_data: got %h want 12", data_out); end
  endtask

  task automatic test_reset_mid_frame();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hF0, 1'b1, -1, -1, 5 * 64 + 32);
    n_vec++; if (snap_data !== 8'h00) begin n_err++; $display("FAIL midrst_data: got %h want 00", snap_data); end
    n_vec++; if (snap_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", snap_valid); end
    n_vec++; if (snap_ferr !== 1'b0) begin n_err++; $display("FAIL midrst_framing: got %b want 0", snap_ferr); end
    n_vec++; if (snap_perr !== 1'b0) begin n_err++; $display("FAIL midrst_parity: got %b want 0", snap_perr); end
    n_vec++; if (snap_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", snap_busy); end
    repeat (128) @(negedge clk);
    n_vec++; if ((n_valid - v0) + (n_ferr - f0) !== 0) begin
      n_err++; $display("FAIL midrst_no_strobe: got %0d want 0", (n_valid - v0) + (n_ferr - f0));
    end
    send_frame(8'h81, 1'b1, -1, -1, -1);
    repeat (128) @(negedge clk);
    n_vec++; if (n_valid - v0 !== 1) begin n_err++; $display("FAIL midrst_next_count: got %0d want 1", n_valid - v0); end
    n_vec++; if (data_out !== 8'h81) begin n_err++; $display("FAIL midrst_next_data: got %h want 81", data_out); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int v0, p0;
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h07, 1'b1, 1, -1, -1);
    repeat (128) @(negedge clk);
    n_vec++; if (n_valid - v0 !== 1) begin n_err++; $display("FAIL parity_ok_valid: got %0d want 1", n_valid - v0); end
    n_vec++; if (n_perr - p0 !== 0) begin n_err++; $display("FAIL parity_ok_err: got %0d want 0", n_perr - p0); end
    n_vec++; if (data_out !== 8'h07) begin n_err++; $display("FAIL parity_ok_data: got %h want 07", data_out); end
    send_frame(8'h07, 1'b1, 0, -1, -1);
    repeat (128) @(negedge clk);
    n_vec++; if (n_valid - v0 !== 2) begin n_err++; $display("FAIL parity_bad_valid: got %0d want 2", n_valid - v0); end
    n_vec++; if (n_perr - p0 !== 1) begin n_err++; $display("FAIL parity_bad_err: got %0d want 1", n_perr - p0); end
    n_vec++; if (n_perr_alone !== 0) begin n_err++; $display("FAIL parity_with_valid: got %0d want 0", n_perr_alone); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch_start();
    test_glitch_data();
    test_framing_break();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`else
    n_vec++; if (n_perr !== 0) begin n_err++; $display("FAIL parity_tied_low: got %0d want 0", n_perr); end
`endif
    n_vec++; if (n_coinc !== 0) begin n_err++; $display("FAIL strobe_coincide: got %0d want 0", n_coinc); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
